add32_rr_arbiter: RTL and testbench

- Shares one Add32 add/sub unit among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshake per requester, single registered response channel tagged with requester ID.
- Sits between the issuing client blocks and the Add32 instance, which it contains. Also keeps a saturating count of overflowing operations.

---
 rtl/add32_rr_arbiter_if.sv | 28 ++
 rtl/add32_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_add32_rr_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/add32_rr_arbiter_if.sv
// Request/response bundle between the client blocks and the shared Add32 arbiter.
// The master side issues operations and consumes responses; the slave side is the arbiter.
interface add32_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic [NUM_REQ-1:0]    req_sign;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_sub, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );
endinterface

// File: rtl/add32_rr_arbiter.sv
// Round-robin arbiter sharing one Add32 add/sub unit among NUM_REQ requesters,
// with a single registered, ID-tagged response channel and a saturating overflow counter.
module add32_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    add32_rr_arbiter_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  ovf_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic               op_sub_q, op_sub_d;
    logic               op_sign_q, op_sign_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    logic [ID_W-1:0]    grant;
    logic               any_valid;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [31:0]        add_result;
    logic               add_ovf;

    logic [31:0] a_arr [NUM_REQ];
    logic [31:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[32*gi +: 32];
            assign b_arr[gi] = bus.req_b[32*gi +: 32];
        end
    endgenerate

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        logic [ID_W:0] idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!any_valid && bus.req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                grant     = idx[ID_W-1:0];
            end
        end
    end

    add32 u_add32 (
        .Overflow (add_ovf),
        .result   (add_result),
        .A        (op_a_q),
        .B        (op_b_q),
        .isSub    (op_sub_q),
        .isSign   (op_sign_q)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_sub_d       = op_sub_q;
        op_sign_d      = op_sign_q;
        op_id_d        = op_id_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        ovf_count_d    = ovf_count_q;
        req_ready_c    = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_c[grant] = 1'b1;
                    op_a_d    = a_arr[grant];
                    op_b_d    = b_arr[grant];
                    op_sub_d  = bus.req_sub[grant];
                    op_sign_d = bus.req_sign[grant];
                    op_id_d   = grant;
                    rr_ptr_d  = grant;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d   = add_result;
                rsp_overflow_d = add_ovf;
                rsp_id_d       = op_id_q;
                rsp_valid_d    = 1'b1;
                if (add_ovf && (ovf_count_q != '1)) begin
                    ovf_count_d = ovf_count_q + CNT_W'(1);
                end
                state_d = DONE;
            end
            DONE: begin
                // Data outputs are left as-is so they stay readable after the handshake.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= ID_W'(NUM_REQ - 1);
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_sub_q       <= 1'b0;
            op_sign_q      <= 1'b0;
            op_id_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            ovf_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_sub_q       <= op_sub_d;
            op_sign_q      <= op_sign_d;
            op_id_q        <= op_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign busy             = (state_q != IDLE);
    assign ovf_count        = ovf_count_q;

endmodule

// 32-bit adder/subtractor with signed and unsigned overflow detection.
module add32 (
    output logic        Overflow,
    output logic [31:0] result,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        isSub,
    input  logic        isSign
);
    logic [31:0] b_eff;
    logic [32:0] sum;

    assign b_eff  = isSub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_eff} + {32'd0, isSub};
    assign result = sum[31:0];

    // Unsigned subtract reports a borrow, which is the inverse of the carry out.
    assign Overflow = isSign ? ((A[31] == b_eff[31]) && (result[31] != A[31]))
                             : (isSub ? ~sum[32] : sum[32]);
endmodule

// File: tb/tb_add32_rr_arbiter.sv
// Directed bench for add32_rr_arbiter: table of single-requester operations plus
// sequences for fairness, response back-pressure and reset during execution.
module tb_add32_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] ovf_count;

    add32_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    add32_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sign;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic sign);
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
        bus.req_sub[id]        = sub;
        bus.req_sign[id]       = sign;
    endtask

    task automatic scramble_inputs();
        bus.req_a    = {$urandom, $urandom, $urandom, $urandom};
        bus.req_b    = {$urandom, $urandom, $urandom, $urandom};
        bus.req_sub  = 4'($urandom);
        bus.req_sign = 4'($urandom);
    endtask

    // Called at negedge+1 with the DUT in IDLE; returns at negedge+1 back in IDLE.
    task automatic run_op(input vec_t v);
        logic [NUM_REQ-1:0] one_hot;
        one_hot = '0;
        one_hot[v.id] = 1'b1;
        scramble_inputs();
        set_req(v.id, v.a, v.b, v.sub, v.sign);
        bus.req_valid = one_hot;
        bus.rsp_ready = 1'b1;
        #1;
        chk("grant", bus.req_ready, one_hot);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        bus.req_valid = '0;
        scramble_inputs();
        #1;
        chk("exec_ready", bus.req_ready, 0);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_busy", busy, 1);
        @(negedge clk);
        #1;
        if (v.ovf) exp_cnt++;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, v.id);
        chk("rsp_result", bus.rsp_result, v.res);
        chk("rsp_overflow", bus.rsp_overflow, v.ovf);
        chk("ovf_count", ovf_count, exp_cnt);
        $display("op id=%0d a=%h b=%h sub=%0d sign=%0d -> result=%h ovf=%0d cnt=%0d",
                 v.id, v.a, v.b, v.sub, v.sign, bus.rsp_result, bus.rsp_overflow, ovf_count);
        @(negedge clk);
        #1;
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("held_result", bus.rsp_result, v.res);
    endtask

    initial begin
        int exp_order [6];
        int grants;
        logic prev_ready;
        logic [NUM_REQ-1:0] one_hot;

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;

        vecs[0] = '{0, 32'hFFFFFF9C, 32'hFFFFFF9C, 1'b0, 1'b1, 32'hFFFFFF38, 1'b0};
        vecs[1] = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b1};
        vecs[2] = '{2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{3, 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1};
        vecs[4] = '{3, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0};
        vecs[5] = '{0, 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1};
        vecs[6] = '{1, 32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b0};
        vecs[7] = '{2, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        scramble_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf_count", ovf_count, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_no_valid_ready", bus.req_ready, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // All requesters continuously valid from reset: grants must rotate 0,1,2,3,0,1.
        rst = 1'b1;
        exp_order = '{0, 1, 2, 3, 0, 1};
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        grants     = 0;
        prev_ready = 1'b0;
        for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
            if (prev_ready) begin
                chk("ready_pulse_width", bus.req_ready, 0);
            end
            prev_ready = (bus.req_ready != '0);
            if (prev_ready) begin
                one_hot = '0;
                one_hot[exp_order[grants]] = 1'b1;
                chk("rr_order", bus.req_ready, one_hot);
                $display("grant %0d req_ready=%b", grants, bus.req_ready);
                grants++;
            end
            @(negedge clk);
            #1;
        end
        chk("rr_grant_count", grants, 6);

        // Back-pressure: hold rsp_ready low in DONE with everyone else requesting.
        bus.req_valid = '0;
        rst = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        set_req(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        #1;
        chk("stall_grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '1;
        scramble_inputs();
        @(negedge clk);
        #1;
        chk("stall_rsp_valid", bus.rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            scramble_inputs();
            #1;
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_result", bus.rsp_result, 32'h80000000);
            chk("stall_id", bus.rsp_id, 1);
            chk("stall_ready", bus.req_ready, 0);
            chk("stall_busy", busy, 1);
        end
        $display("stall released id=%0d result=%h", bus.rsp_id, bus.rsp_result);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release_busy", busy, 0);
        chk("release_rsp_valid", bus.rsp_valid, 0);
        chk("release_next_grant", bus.req_ready, 4'b0100);
        chk("release_ovf_count", ovf_count, 1);

        // Asynchronous reset while the grant to requester 2 is executing.
        @(negedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_ovf_count", ovf_count, 0);
        chk("async_rst_busy", busy, 0);
        bus.req_valid = 4'b0100;
        set_req(2, 32'h00000010, 32'h00000003, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_hold_rsp_valid", bus.rsp_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("post_rst_exec_valid", bus.rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("post_rst_rsp_valid", bus.rsp_valid, 1);
        chk("post_rst_rsp_id", bus.rsp_id, 2);
        chk("post_rst_result", bus.rsp_result, 32'h0000000D);
        chk("post_rst_ovf", bus.rsp_overflow, 0);
        $display("post-reset op id=%0d result=%h", bus.rsp_id, bus.rsp_result);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
